// File: rtl/output_display.sv
`default_nettype none
// ============================================================================
//  Module      : output_display
//  Description : Output register and display driver. Captures an 8-bit bus
//                value on a load strobe, converts it to BCD with a
//                sequential double-dabble FSM (optionally two's-complement
//                signed) and scans it onto a 4-digit multiplexed
//                seven-segment display.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_display #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] bus,
    input  logic       signed_mode,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    // Prescaler width; a single-cycle divider still needs a 1-bit counter.
    localparam int              c_PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(SCAN_DIV - 1);

    state_t          r_state;
    logic [2:0]      r_step;
    logic [19:0]     r_shift;       // {hundreds, tens, ones, magnitude}
    logic            r_neg;
    logic            r_busy;
    logic [11:0]     r_disp_bcd;
    logic            r_disp_neg;
    logic [c_PW-1:0] r_presc;
    logic [1:0]      r_idx;

    logic            w_in_neg;
    logic [7:0]      w_in_mag;
    logic [11:0]     w_adj_bcd;
    logic [19:0]     w_next_shift;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            default: code = 7'h00;
        endcase
        return code;
    endfunction

    // Magnitude of the captured value; signed 0x80 naturally yields 128.
    assign w_in_neg = signed_mode & bus[7];
    assign w_in_mag = w_in_neg ? (~bus + 8'd1) : bus;

    // One double-dabble step: add 3 to every nibble >= 5, then shift left.
    assign w_adj_bcd    = {add3(r_shift[19:16]), add3(r_shift[15:12]), add3(r_shift[11:8])};
    assign w_next_shift = {w_adj_bcd[10:0], r_shift[7:0], 1'b0};

    // Conversion FSM: capture on load, eight shift steps, then publish.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_step     <= 3'd0;
            r_shift    <= 20'd0;
            r_neg      <= 1'b0;
            r_busy     <= 1'b0;
            r_disp_bcd <= 12'd0;
            r_disp_neg <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_shift <= {12'd0, w_in_mag};
                        r_neg   <= w_in_neg;
                        r_step  <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_shift <= w_next_shift;
                    r_step  <= r_step + 3'd1;
                    if (r_step == 3'd7) begin
                        r_disp_bcd <= w_next_shift[19:8];
                        r_disp_neg <= r_neg;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Digit scanner: advance the digit index each time the prescaler wraps.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
        end else if (r_presc == c_PRESC_MAX) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Segment and anode drive for the currently selected digit, with
    // leading-zero blanking and a sign digit.
    always_comb begin
        an  = 4'b0001 << r_idx;
        seg = 7'h00;
        case (r_idx)
            2'd0: seg = seg_code(r_disp_bcd[3:0]);
            2'd1: seg = ((r_disp_bcd[11:8] == 4'd0) && (r_disp_bcd[7:4] == 4'd0))
                        ? 7'h00 : seg_code(r_disp_bcd[7:4]);
            2'd2: seg = (r_disp_bcd[11:8] == 4'd0) ? 7'h00 : seg_code(r_disp_bcd[11:8]);
            default: seg = r_disp_neg ? 7'h40 : 7'h00;
        endcase
    end

    assign busy = r_busy;

endmodule
`default_nettype wire
